// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host frame receiver with glitch filter, frame checking, watchdog timeout and FWFT receive FIFO
// Parameters: FILTER_LEN (ps2c filter length), FIFO_AW (FIFO address width, depth 2**FIFO_AW), TIMEOUT_CYC (max cycles between falls in a frame)
// Ports: clk, reset (async active-low), ps2d/ps2c (raw PS/2 lines), rx_en (allow new frame), rd_en (pop),
//        dout (FIFO head, 8'h00 when empty), empty, full, rx_busy, frame_err_tick, ovf_tick
// Macro: PS2_RX_PARITY_CHECK_EN enables odd-parity checking; otherwise only start and stop bits are checked
module ps2_rx_fifo #(
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_AW     = 2,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2d,
    input  logic       ps2c,
    input  logic       rx_en,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full,
    output logic       rx_busy,
    output logic       frame_err_tick,
    output logic       ovf_tick
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
    state_t                state_q, state_d;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  fc_q, fc_d, fall;
    logic [3:0]            n_q, n_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [10:0]           frame_q, frame_d;
    logic [FIFO_AW:0]      wp_q, rp_q;
    logic [7:0]            mem [2**FIFO_AW];
    logic                  valid, push, pop;
    assign filt_d = {ps2c, filt_q[FILTER_LEN-1:1]};
    assign fc_d   = (&filt_d) ? 1'b1 : (~|filt_d) ? 1'b0 : fc_q;
    assign fall   = fc_q & ~fc_d;
`ifdef PS2_RX_PARITY_CHECK_EN
    assign valid = ~frame_q[0] & frame_q[10] & (^frame_q[9:1]);
`else
    assign valid = ~frame_q[0] & frame_q[10];
`endif
    assign empty   = wp_q == rp_q;
    assign full    = (wp_q[FIFO_AW] != rp_q[FIFO_AW]) && (wp_q[FIFO_AW-1:0] == rp_q[FIFO_AW-1:0]);
    assign pop     = rd_en & ~empty;
    assign dout    = empty ? 8'h00 : mem[rp_q[FIFO_AW-1:0]];
    assign rx_busy = state_q != IDLE;
    always_comb begin
        state_d        = state_q;
        n_d            = n_q;
        tmo_d          = tmo_q;
        frame_d        = frame_q;
        push           = 1'b0;
        frame_err_tick = 1'b0;
        ovf_tick       = 1'b0;
        case (state_q)
            IDLE: if (fall && rx_en) begin
                frame_d = {ps2d, frame_q[10:1]};
                n_d     = 4'd9;
                tmo_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: if (fall) begin
                frame_d = {ps2d, frame_q[10:1]};
                tmo_d   = '0;
                if (n_q == 4'd0) state_d = CHECK;
                else n_d = n_q - 4'd1;
            end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                frame_err_tick = 1'b1;
                state_d        = IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
            CHECK: begin
                state_d        = IDLE;
                // a full FIFO still accepts the byte when the head is popped this cycle
                push           = valid & (~full | pop);
                ovf_tick       = valid & full & ~pop;
                frame_err_tick = ~valid;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            filt_q  <= '0;
            fc_q    <= 1'b0;
            n_q     <= '0;
            tmo_q   <= '0;
            frame_q <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            fc_q    <= fc_d;
            n_q     <= n_d;
            tmo_q   <= tmo_d;
            frame_q <= frame_d;
            wp_q    <= wp_q + (FIFO_AW + 1)'(push);
            rp_q    <= rp_q + (FIFO_AW + 1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp_q[FIFO_AW-1:0]] <= frame_q[8:1];
    end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: scoreboard bench for ps2_rx_fifo with a queue-based FIFO reference model
module tb_ps2_rx_fifo;
    localparam int FL = 8, AW = 2, TO = 100, H = 12, DEPTH = 4;
`ifdef PS2_RX_PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    logic       clk = 1'b0, reset = 1'b0, ps2d = 1'b1, ps2c = 1'b1, rx_en = 1'b1, rd_en = 1'b0;
    logic [7:0] dout;
    logic       empty, full, rx_busy, frame_err_tick, ovf_tick;
    int         checks = 0, failures = 0, ev;
    logic [7:0] mq[$], exp_rd[$];
    int         exp_ev[$];

    ps2_rx_fifo #(.FILTER_LEN(FL), .FIFO_AW(AW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rx_en(rx_en), .rd_en(rd_en),
        .dout(dout), .empty(empty), .full(full), .rx_busy(rx_busy),
        .frame_err_tick(frame_err_tick), .ovf_tick(ovf_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: 1 = frame error tick, 2 = overflow tick
    always @(negedge clk) begin
        #1;
        if (reset) begin
            if (frame_err_tick || ovf_tick) begin
                ev = frame_err_tick ? 1 : 2;
                if (exp_ev.size() == 0) chk("tick_pending", exp_ev.size(), 1);
                else chk("tick_kind", ev, exp_ev.pop_front());
            end
            if (rd_en && !empty) begin
                if (exp_rd.size() == 0) chk("pop_pending", exp_rd.size(), 1);
                else chk("pop_dout", dout, exp_rd.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_state(input string name);
        chk({name, "_empty"}, empty, mq.size() == 0);
        chk({name, "_full"}, full, mq.size() == DEPTH);
        if (mq.size() == 0) chk({name, "_dout0"}, dout, 8'h00);
        else chk({name, "_head"}, dout, mq[0]);
    endtask

    task automatic rd();
        @(negedge clk) rd_en = 1'b1;
        if (mq.size() != 0) exp_rd.push_back(mq.pop_front());
        @(negedge clk) rd_en = 1'b0;
    endtask

    // kind: 0 good, 1 bad start, 2 bad stop, 3 bad parity; rdc raises rd_en in the CHECK cycle
    task automatic send(input logic [7:0] d, input int kind, input int nbits, input bit rdc);
        logic [10:0] f;
        logic        par;
        bit          ok;
        par = ~^d;
        f   = {kind != 2, (kind == 3) ? ~par : par, d, kind == 1};
        ok  = (kind == 0) || (kind == 3 && !PAR);
        if (nbits == 11 && rx_en) begin
            if (rdc && mq.size() != 0) exp_rd.push_back(mq.pop_front());
            if (!ok) exp_ev.push_back(1);
            else if (mq.size() < DEPTH) mq.push_back(d);
            else exp_ev.push_back(2);
        end
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk) ps2d = f[i];
            idle(2);
            ps2c = 1'b0;
            if (i == 10 && rdc) begin
                repeat (FL) @(posedge clk);
                @(negedge clk) rd_en = 1'b1;
                @(negedge clk) rd_en = 1'b0;
                idle(H - FL);
            end else begin
                idle(H);
            end
            ps2c = 1'b1;
            idle(H);
        end
        idle(4);
    endtask

    initial begin
        int k;
        #2;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_dout", dout, 8'h00);
        chk("rst_busy", rx_busy, 0);
        chk("rst_ticks", {frame_err_tick, ovf_tick}, 0);
        @(negedge clk) reset = 1'b1;
        idle(20);
        chk_state("idle");
        send(8'h1C, 0, 11, 0);
        chk("dout_1c", dout, 8'h1C);
        chk_state("one");
        rd();
        chk_state("drained");
        foreach (mq[i]) mq.delete(i);
        send(8'h1C, 0, 11, 0); send(8'h32, 0, 11, 0); send(8'h21, 0, 11, 0); send(8'h23, 0, 11, 0);
        chk("full4", full, 1);
        send(8'hF0, 0, 11, 0);
        chk_state("ovf");
        repeat (4) rd();
        chk_state("ovf_drained");
        send(8'h1C, 0, 11, 0); send(8'h32, 0, 11, 0); send(8'h21, 0, 11, 0); send(8'h23, 0, 11, 0);
        send(8'hF0, 0, 11, 1);
        chk("full_after_rdcheck", full, 1);
        chk_state("rdcheck");
        repeat (4) rd();
        send(8'hAA, 2, 11, 0);
        send(8'h55, 3, 11, 0);
        chk_state("bad_frames");
        while (mq.size() != 0) rd();
        exp_ev.push_back(1);
        send(8'h00, 0, 5, 0);
        idle(TO + 50);
        chk("timeout_busy", rx_busy, 0);
        chk("timeout_seen", exp_ev.size(), 0);
        send(8'h5A, 0, 11, 0);
        chk("dout_5a", dout, 8'h5A);
        rd();
        rx_en = 1'b0;
        send(8'h77, 0, 11, 0);
        rx_en = 1'b1;
        chk_state("rx_en_off");
        @(negedge clk) ps2c = 1'b0;
        idle(FL - 1);
        ps2c = 1'b1;
        idle(20);
        chk("glitch_busy", rx_busy, 0);
        send(8'h3C, 0, 11, 0);
        chk_state("after_glitch");
        send(8'h81, 0, 11, 0);
        send(8'h42, 0, 4, 0);
        @(negedge clk) reset = 1'b0;
        #2;
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_dout", dout, 8'h00);
        chk("mid_rst_busy", rx_busy, 0);
        chk("mid_rst_ticks", {frame_err_tick, ovf_tick}, 0);
        mq.delete(); exp_rd.delete(); exp_ev.delete();
        ps2c = 1'b1; ps2d = 1'b1;
        @(negedge clk) reset = 1'b1;
        idle(20);
        for (int it = 0; it < 25; it++) begin
            k = $urandom_range(0, 6);
            send(8'($urandom), (k > 3) ? 0 : k, 11, 0);
            chk_state("rnd_rx");
            repeat ($urandom_range(0, 2)) rd();
            chk_state("rnd_rd");
        end
        idle(20);
        chk("drained_queues", exp_ev.size() + exp_rd.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
